// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and
// byte-lane select, extend and merge helpers for 32-bit little-endian words.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int WORD_W = 32;
    localparam int LANE_W = 8;
    localparam int LANE_N = WORD_W / LANE_W;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    // Lane 0 is bits [7:0], lane 3 is bits [31:24].
    function automatic logic [LANE_W-1:0] lane_get(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        lane);
        return word[lane*LANE_W +: LANE_W];
    endfunction

    function automatic logic [WORD_W-1:0] lane_extend(input logic [LANE_W-1:0] b,
                                                      input logic              sext);
        if (sext == EXT_SIGN)
            return {{(WORD_W-LANE_W){b[LANE_W-1]}}, b};
        return {{(WORD_W-LANE_W){1'b0}}, b};
    endfunction

    function automatic logic [WORD_W-1:0] lane_put(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        lane,
                                                   input logic [LANE_W-1:0] b);
        logic [WORD_W-1:0] merged;
        merged = word;
        merged[lane*LANE_W +: LANE_W] = b;
        return merged;
    endfunction

endpackage

// File: rtl/dmem_lsu_ram.sv
// Single-clock word memory: one read port with a registered output and one
// write port; contents optionally start at zero.
module dmem_ram
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH] = '{default: (INIT_ZERO != 0) ? {WORD_W{1'b0}} : {WORD_W{1'bx}}};

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: one request at a time, byte stores done as
// read-modify-write, misaligned word accesses answered with an error.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    state_t state, state_nxt;

    logic              op_we;
    logic              op_byte;
    logic              op_sext;
    logic [ADDR_W+1:0] op_addr;
    logic [31:0]       op_wdata;
    logic              op_err;

    logic              ram_rd_en;
    logic              ram_wr_en;
    logic [31:0]       ram_rd_data;
    logic [31:0]       ram_wr_data;

    logic              handshake;
    logic              misaligned;
    logic [31:0]       load_word;

    // Upper address bits wrap modulo the memory depth.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign handshake  = req_valid && (state == ST_IDLE);
    assign misaligned = !req_byte && (req_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_we    <= 1'b0;
            op_byte  <= 1'b0;
            op_sext  <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            op_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                op_we    <= req_we;
                op_byte  <= req_byte;
                op_sext  <= req_sext;
                op_addr  <= req_addr[ADDR_W+1:0];
                op_wdata <= req_wdata;
                op_err   <= misaligned;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ram_rd_en   = 1'b0;
        ram_wr_en   = 1'b0;
        ram_wr_data = op_wdata;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (misaligned)
                        state_nxt = ST_RESP;
                    else if (req_we && !req_byte)
                        state_nxt = ST_WR;
                    else
                        state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                ram_rd_en = 1'b1;
                state_nxt = op_we ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                // A byte store arrives here one cycle after its read, so the
                // RAM output still holds the word to be merged.
                ram_wr_en = 1'b1;
                if (op_byte)
                    ram_wr_data = lane_put(ram_rd_data, op_addr[1:0], op_wdata[LANE_W-1:0]);
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The RAM output register is only reloaded in RD, so the load result is
    // stable for the whole RESP phase without a separate holding register.
    assign load_word = op_byte ? lane_extend(lane_get(ram_rd_data, op_addr[1:0]), op_sext)
                               : ram_rd_data;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = (state == ST_RESP) && op_err;
    assign rsp_rdata = ((state == ST_RESP) && !op_we && !op_err) ? load_word : '0;

    dmem_ram #(
        .ADDR_W    (ADDR_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_ram (
        .clk     (clk),
        .rd_en   (ram_rd_en),
        .rd_addr (op_addr[ADDR_W+1:2]),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_addr (op_addr[ADDR_W+1:2]),
        .wr_data (ram_wr_data)
    );

endmodule
